// File: rtl/vote_tally.sv
// Ballot-collection unit: one vote per issued ballot, saturating per-candidate counts,
// with results frozen once the poll is closed.
module vote_tally #(
    parameter int N_CAND  = 3,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ballot_issue,
    input  logic                    close_poll,
    input  logic                    clear_counts,
    input  logic                    vote_valid,
    input  logic [1:0]              vote_sel,
    output logic [4*N_CAND-1:0]     candidate_numbers,
    output logic [CNT_W*N_CAND-1:0] vote_counts,
    output logic [CNT_W+1:0]        total_votes,
    output logic                    vote_ack,
    output logic                    vote_err,
    output logic                    ballot_timeout,
    output logic                    overflow,
    output logic                    ballot_open,
    output logic                    results_valid
);

    localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int TOT_W = CNT_W + 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_ONE = 1;
    localparam logic [TW-1:0]    TMO_ONE = 1;
    localparam logic [TW-1:0]    TMO_END = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CLOSED
    } state_t;

    state_t                         state_q, state_d;
    logic [TW-1:0]                  tmo_q, tmo_d;
    logic [N_CAND-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [TOT_W-1:0]               tot_q, tot_d;
    logic                           ovf_q, ovf_d;
    logic                           ack_q, ack_d;
    logic                           err_q, err_d;
    logic                           to_q, to_d;
    logic                           sel_ok;

    assign sel_ok = (int'(vote_sel) < N_CAND);

    always_comb begin
        candidate_numbers = '0;
        for (int unsigned i = 0; i < N_CAND; i++) begin
            candidate_numbers[4*i +: 4] = 4'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        tot_d   = tot_q;
        ovf_d   = ovf_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (close_poll) begin
                    state_d = S_CLOSED;
                end else if (clear_counts) begin
                    cnt_d = '0;
                    tot_d = '0;
                    ovf_d = 1'b0;
                end else if (ballot_issue) begin
                    state_d = S_ARMED;
                    tmo_d   = '0;
                end
            end
            S_ARMED: begin
                if (vote_valid && sel_ok) begin
                    for (int unsigned i = 0; i < N_CAND; i++) begin
                        if (vote_sel == 2'(i)) begin
                            if (cnt_q[i] == CNT_MAX) ovf_d = 1'b1;
                            else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                    if (tot_q != TOT_MAX) tot_d = tot_q + TOT_ONE;
                    ack_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // An out-of-range press does not stop the ballot from ageing.
                    err_d = vote_valid;
                    if (tmo_q == TMO_END) begin
                        to_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end
            end
            S_CLOSED: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            cnt_q   <= '0;
            tot_q   <= '0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            tot_q   <= tot_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign vote_counts    = cnt_q;
    assign total_votes    = tot_q;
    assign overflow       = ovf_q;
    assign vote_ack       = ack_q;
    assign vote_err       = err_q;
    assign ballot_timeout = to_q;
    assign ballot_open    = (state_q == S_ARMED);
    assign results_valid  = (state_q == S_CLOSED);

endmodule

// File: tb/tb_vote_tally.sv
// Self-checking bench for vote_tally: directed scenarios plus randomized ballots
// checked against a transaction-level tally model.
module tb_vote_tally;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ballot_issue = 1'b0;
    logic        close_poll = 1'b0;
    logic        clear_counts = 1'b0;
    logic        vote_valid = 1'b0;
    logic [1:0]  vote_sel = 2'd0;
    logic [11:0] candidate_numbers;
    logic [11:0] vote_counts;
    logic [5:0]  total_votes;
    logic        vote_ack, vote_err, ballot_timeout, overflow, ballot_open, results_valid;

    int checks = 0;
    int failures = 0;

    // Reference tally
    int m_cnt[3];
    int m_tot;
    bit m_ovf;

    vote_tally #(.N_CAND(3), .CNT_W(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ballot_issue(ballot_issue), .close_poll(close_poll), .clear_counts(clear_counts),
        .vote_valid(vote_valid), .vote_sel(vote_sel),
        .candidate_numbers(candidate_numbers), .vote_counts(vote_counts),
        .total_votes(total_votes), .vote_ack(vote_ack), .vote_err(vote_err),
        .ballot_timeout(ballot_timeout), .overflow(overflow),
        .ballot_open(ballot_open), .results_valid(results_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_tot = 0;
        m_ovf = 0;
    endfunction

    function automatic void model_vote(input int sel);
        if (m_cnt[sel] == 15) m_ovf = 1;
        else m_cnt[sel] = m_cnt[sel] + 1;
        m_tot = (m_tot + 1 > 63) ? 63 : m_tot + 1;
    endfunction

    function automatic logic [11:0] exp_bus();
        return {4'(m_cnt[2]), 4'(m_cnt[1]), 4'(m_cnt[0])};
    endfunction

    task automatic do_vote(input int sel, output logic ack_seen);
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        vote_valid = 1'b1;
        vote_sel = 2'(sel);
        tick();
        ack_seen = vote_ack;
        vote_valid = 1'b0;
        model_vote(sel);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        model_clear();
        checks++;
        if ({vote_counts, total_votes, vote_ack, vote_err, ballot_timeout, overflow, ballot_open, results_valid} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: counts=%h total=%0d pulses=%b%b%b ovf=%b open=%b rv=%b required all zero",
                     vote_counts, total_votes, vote_ack, vote_err, ballot_timeout, overflow, ballot_open, results_valid);
        end
        checks++;
        if (candidate_numbers !== 12'h210) begin
            failures++;
            $display("FAIL reset_cand_numbers: got=%h required=210", candidate_numbers);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic ack;
        int sels[3] = '{2, 2, 1};
        for (int i = 0; i < 3; i++) begin
            do_vote(sels[i], ack);
            checks++;
            if (ack !== 1'b1 || ballot_open !== 1'b0) begin
                failures++;
                $display("FAIL basic_ack%0d: ack=%b open=%b required ack=1 open=0", i, ack, ballot_open);
            end
        end
        checks++;
        if (vote_counts !== exp_bus() || total_votes !== 6'(m_tot)) begin
            failures++;
            $display("FAIL basic_counts: counts=%h total=%0d required counts=%h total=%0d",
                     vote_counts, total_votes, exp_bus(), m_tot);
        end
    endtask

    task automatic test_level_vote();
        int acks = 0;
        vote_valid = 1'b1;
        vote_sel = 2'd0;
        tick();
        tick();
        checks++;
        if (vote_counts !== exp_bus() || vote_ack !== 1'b0) begin
            failures++;
            $display("FAIL idle_vote_ignored: counts=%h ack=%b required counts=%h ack=0", vote_counts, vote_ack, exp_bus());
        end
        for (int b = 0; b < 2; b++) begin
            ballot_issue = 1'b1;
            tick();
            ballot_issue = 1'b0;
            acks += int'(vote_ack);
            for (int c = 0; c < 3; c++) begin
                tick();
                acks += int'(vote_ack);
            end
            model_vote(0);
        end
        vote_valid = 1'b0;
        checks++;
        if (acks != 2 || vote_counts !== exp_bus()) begin
            failures++;
            $display("FAIL level_vote: acks=%0d counts=%h required acks=2 counts=%h", acks, vote_counts, exp_bus());
        end
    endtask

    task automatic test_bad_sel();
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        vote_valid = 1'b1;
        vote_sel = 2'd3;
        tick();
        checks++;
        if (vote_err !== 1'b1 || vote_ack !== 1'b0 || ballot_open !== 1'b1 || vote_counts !== exp_bus()) begin
            failures++;
            $display("FAIL bad_sel: err=%b ack=%b open=%b counts=%h required err=1 ack=0 open=1 counts=%h",
                     vote_err, vote_ack, ballot_open, vote_counts, exp_bus());
        end
        vote_sel = 2'd1;
        tick();
        vote_valid = 1'b0;
        model_vote(1);
        checks++;
        if (vote_ack !== 1'b1 || vote_err !== 1'b0 || ballot_open !== 1'b0 || vote_counts !== exp_bus()) begin
            failures++;
            $display("FAIL bad_sel_recover: ack=%b err=%b open=%b counts=%h required ack=1 err=0 open=0 counts=%h",
                     vote_ack, vote_err, ballot_open, vote_counts, exp_bus());
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        while (ballot_open === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 16 || ballot_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_len: open_cycles=%0d timeout=%b required 16 and 1", n, ballot_timeout);
        end
        tick();
        checks++;
        if (ballot_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse_width: timeout=%b required 0", ballot_timeout);
        end
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        repeat (15) tick();
        vote_valid = 1'b1;
        vote_sel = 2'd2;
        tick();
        vote_valid = 1'b0;
        model_vote(2);
        checks++;
        if (vote_ack !== 1'b1 || ballot_timeout !== 1'b0 || vote_counts !== exp_bus()) begin
            failures++;
            $display("FAIL vote_at_expiry: ack=%b timeout=%b counts=%h required ack=1 timeout=0 counts=%h",
                     vote_ack, ballot_timeout, vote_counts, exp_bus());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                clear_counts = 1'b1;
                tick();
                clear_counts = 1'b0;
                model_clear();
            end else begin
                int  age = 0;
                bit  done = 0;
                ballot_issue = 1'b1;
                tick();
                ballot_issue = 1'b0;
                while (!done) begin
                    bit press = ($urandom_range(0, 5) == 0);
                    int sel = $urandom_range(0, 3);
                    bit e_ack = 0, e_err = 0, e_to = 0;
                    vote_valid = press;
                    vote_sel = 2'(sel);
                    if (press && sel < 3) begin
                        e_ack = 1;
                        model_vote(sel);
                        done = 1;
                    end else begin
                        e_err = press;
                        if (age == 15) begin
                            e_to = 1;
                            done = 1;
                        end else begin
                            age++;
                        end
                    end
                    tick();
                    vote_valid = 1'b0;
                    checks++;
                    if (vote_ack !== e_ack || vote_err !== e_err || ballot_timeout !== e_to || ballot_open !== !done) begin
                        failures++;
                        $display("FAIL rand_pulses it=%0d age=%0d: ack=%b err=%b to=%b open=%b required %b %b %b %b",
                                 it, age, vote_ack, vote_err, ballot_timeout, ballot_open, e_ack, e_err, e_to, !done);
                    end
                end
            end
            checks++;
            if (vote_counts !== exp_bus() || total_votes !== 6'(m_tot) || overflow !== m_ovf) begin
                failures++;
                $display("FAIL rand_tally it=%0d: counts=%h total=%0d ovf=%b required counts=%h total=%0d ovf=%b",
                         it, vote_counts, total_votes, overflow, exp_bus(), m_tot, m_ovf);
            end
        end
    endtask

    task automatic test_overflow_clear();
        logic ack;
        int acks = 0;
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        model_clear();
        for (int i = 0; i < 17; i++) begin
            do_vote(0, ack);
            acks += int'(ack);
        end
        checks++;
        if (acks != 17 || vote_counts[3:0] !== 4'd15 || overflow !== 1'b1 || total_votes !== 6'd17) begin
            failures++;
            $display("FAIL overflow: acks=%0d count0=%0d ovf=%b total=%0d required 17 15 1 17",
                     acks, vote_counts[3:0], overflow, total_votes);
        end
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        model_clear();
        checks++;
        if (vote_counts !== 12'h000 || total_votes !== 6'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL clear: counts=%h total=%0d ovf=%b required 000 0 0", vote_counts, total_votes, overflow);
        end
    endtask

    task automatic test_close_and_reset();
        logic ack;
        do_vote(2, ack);
        do_vote(2, ack);
        do_vote(1, ack);
        close_poll = 1'b1;
        tick();
        close_poll = 1'b0;
        checks++;
        if (results_valid !== 1'b1 || vote_counts !== 12'h210 || total_votes !== 6'd3 || candidate_numbers !== 12'h210) begin
            failures++;
            $display("FAIL close_results: rv=%b counts=%h total=%0d cand=%h required 1 210 3 210",
                     results_valid, vote_counts, total_votes, candidate_numbers);
        end
        ballot_issue = 1'b1;
        vote_valid = 1'b1;
        vote_sel = 2'd0;
        clear_counts = 1'b1;
        repeat (4) tick();
        ballot_issue = 1'b0;
        vote_valid = 1'b0;
        clear_counts = 1'b0;
        checks++;
        if (vote_counts !== 12'h210 || total_votes !== 6'd3 || ballot_open !== 1'b0 || vote_ack !== 1'b0 || results_valid !== 1'b1) begin
            failures++;
            $display("FAIL closed_frozen: counts=%h total=%0d open=%b ack=%b rv=%b required 210 3 0 0 1",
                     vote_counts, total_votes, ballot_open, vote_ack, results_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (vote_counts !== 12'h000 || total_votes !== 6'd0 || results_valid !== 1'b0 || candidate_numbers !== 12'h210) begin
            failures++;
            $display("FAIL async_reset: counts=%h total=%0d rv=%b cand=%h required 000 0 0 210",
                     vote_counts, total_votes, results_valid, candidate_numbers);
        end
        tick();
        rst_n = 1'b1;
        do_vote(1, ack);
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (ballot_open !== 1'b0 || vote_counts !== 12'h000 || vote_ack !== 1'b0 || ballot_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_armed: open=%b counts=%h ack=%b to=%b required 0 000 0 0",
                     ballot_open, vote_counts, vote_ack, ballot_timeout);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level_vote();
        test_bad_sel();
        test_timeout();
        test_random();
        test_overflow_clear();
        test_close_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
